fpu_issue_ctrl: RTL and testbench
=================================

# fpu_issue_ctrl

Sequencing front-end that sits directly upstream of `fpu_alu`. It accepts one FP operation at a time from the core over a valid/ready request channel, resolves the rounding mode against the `frm` field of the local `fcsr`, and rejects illegal encodings. For legal operations it drives and holds the ALU start until done, then returns result and exception flags over a valid/ready response channel. It owns the architectural `fcsr` (`frm` plus sticky `fflags`) and accumulates flags on every completed operation.

## Interface
- `TIMEOUT_CYCLES`, 64: maximum BUSY cycles before an operation is abandoned (legal range 2..255).
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low (0 = reset).
- `req_valid`  in  1  operation request.
- `req_ready`  out  1  high only in IDLE.
- `req_alusel`  in  5  ALU select encoding, same as `fpu_alu` `ALUsel`.
- `req_rm`  in  3  instruction rounding mode; 3'b111 = dynamic.
- `req_a`, `req_b`, `req_c`  in  32 each  operands.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  response consumed.
- `resp_result`  out  32  result.
- `resp_flags`  out  5  {NV,DZ,OF,UF,NX} of this operation.
- `resp_illegal`  out  1  op rejected (bad rm or ALUsel).
- `resp_timeout`  out  1  op abandoned by watchdog.
- `alu_start`  out  1  to `fpu_alu.start`.
- `alu_sel`  out  5  to `ALUsel`.
- `alu_frm`  out  3  resolved rounding mode to `frm`.
- `alu_a`, `alu_b`, `alu_c`  out  32 each  to `operA/B/C_float32`.
- `alu_result`  in  32  from `result`.
- `alu_flags`  in  5  from `f_flags`.
- `alu_done`  in  1  from `done`.
- `csr_addr`  in  2  00 none, 01 fflags, 10 frm, 11 fcsr.
- `csr_we`  in  1  CSR write strobe.
- `csr_wdata`  in  8  write data, low bits used per address.
- `csr_rdata`  out  8  combinational read, zero-extended per address; 0 for addr 00.
- `fcsr`  out  8  {frm[2:0], fflags[4:0]}.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch `alu_sel`, `alu_a/b/c`, and resolve rm: `req_rm` if not 111, else current `fcsr.frm` before any same-cycle CSR write.
- Illegal request: resolved rm in {101,110,111}, or ALUsel not in {00000–00011, 00110–10001, 10011, 10101, 11001, 11011, 11101, 11111}.
  - Go to RESP with `resp_result`=0, `resp_flags`=0, `resp_illegal`=1.
  - `alu_start` is never raised; fflags unchanged.
- Legal request: go to BUSY and clear the watchdog counter.
- BUSY: `alu_start`=1 every cycle. `alu_done` is sampled only in BUSY; single-cycle ops report done combinationally in the first BUSY cycle.
  - On `alu_done`=1: capture `alu_result`/`alu_flags` into the response registers, set fflags |= `alu_flags`, go to RESP.
  - Else the counter increments. When counter = `TIMEOUT_CYCLES`-1 with no done, go to RESP with `resp_result`=32'h7FC00000, `resp_flags`=5'b10000, `resp_timeout`=1, and fflags[4] (NV) set.
  - Done in the same cycle as expiry: done wins.
- RESP: `resp_valid`=1, `alu_start`=0, all resp_* held stable. Leave on `resp_ready` to IDLE.
- CSR write: fflags_next = (write hits fflags/fcsr ? `csr_wdata`[4:0] : fflags) | captured flags. Same-cycle capture therefore ORs on top of the written value. frm writes take effect next cycle; an op already in BUSY keeps its latched `alu_frm`.

## Timing
- Reset (`rst`=0 at edge): state IDLE; counter 0; `fcsr` 0. All alu_* outputs 0. `resp_valid`, `resp_illegal`, `resp_timeout`, `resp_result`, `resp_flags` all 0. Reset mid-BUSY drops the op with no response.
- Handshake at edge T (IDLE, `req_valid`): BUSY from T+1.
- Single-cycle op: done in T+1, `resp_valid` from T+2. Multi-cycle op: `resp_valid` 1 cycle after the first done cycle.
- Illegal op: `resp_valid` at T+1.
- `req_ready`=0 from T+1 until the cycle after the RESP handshake. Minimum issue interval is 3 cycles, which guarantees `alu_start` is low for at least one cycle between ops.
- Watchdog: response at BUSY entry + `TIMEOUT_CYCLES` cycles.

## Test plan
- fadd (00000) a=3F800000, b=40000000, rm=000, ALU model done after 4 cycles with 40400000, flags 0 -> `alu_start` high exactly 4 cycles; `resp_result`=40400000; `resp_valid` 5 cycles after acceptance; fflags=0.
- `fcsr.frm`=011, req_rm=111, fsgnj (00110) -> `alu_frm`=011; `resp_valid` 2 cycles after acceptance; then req_rm=111 with frm=101 -> `resp_illegal`=1, `alu_start` never asserted, `resp_valid` next cycle.
- Two ops returning flags 00001 then 00100 -> fflags=00101; CSR write fflags=0 in the capture cycle of a 10000 result -> fflags=10000.
- ALU model never asserts done, TIMEOUT_CYCLES=8 -> response 8 cycles after BUSY entry; result 7FC00000, flags 10000, `resp_timeout`=1, fflags[4]=1.
- Response held with `resp_ready`=0 for 5 cycles -> resp_* stable, `req_ready`=0. ALUsel=10100 -> illegal.
- `rst`=0 mid-BUSY -> next cycle IDLE, `alu_start`=0, `fcsr`=0, no response issued.

Source files
------------

// File: rtl/fpu_issue_ctrl_if.sv
// Core/ALU/CSR signal bundle for fpu_issue_ctrl; slave is the controller, master is its environment.
// Pure wiring, no logic.
interface fpu_issue_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_alusel;
   logic [2:0]  req_rm;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [31:0] req_c;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_result;
   logic [4:0]  resp_flags;
   logic        resp_illegal;
   logic        resp_timeout;
   logic        alu_start;
   logic [4:0]  alu_sel;
   logic [2:0]  alu_frm;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_c;
   logic [31:0] alu_result;
   logic [4:0]  alu_flags;
   logic        alu_done;
   logic [1:0]  csr_addr;
   logic        csr_we;
   logic [7:0]  csr_wdata;
   logic [7:0]  csr_rdata;
   logic [7:0]  fcsr;

   modport slave (
      input  req_valid, req_alusel, req_rm, req_a, req_b, req_c, resp_ready,
      input  alu_result, alu_flags, alu_done, csr_addr, csr_we, csr_wdata,
      output req_ready, resp_valid, resp_result, resp_flags, resp_illegal, resp_timeout,
      output alu_start, alu_sel, alu_frm, alu_a, alu_b, alu_c, csr_rdata, fcsr
   );

   modport master (
      output req_valid, req_alusel, req_rm, req_a, req_b, req_c, resp_ready,
      output alu_result, alu_flags, alu_done, csr_addr, csr_we, csr_wdata,
      input  req_ready, resp_valid, resp_result, resp_flags, resp_illegal, resp_timeout,
      input  alu_start, alu_sel, alu_frm, alu_a, alu_b, alu_c, csr_rdata, fcsr
   );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// One-at-a-time FP issue front-end: resolves rm, rejects illegal ops, holds ALU start until done/watchdog.
// Response 1 cycle after done (illegal: next cycle); req_ready only in IDLE, response held until resp_ready.
module fpu_issue_ctrl #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic           clk,
   input logic           rst,
   fpu_issue_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [4:0]  sel_q, sel_d;
   logic [2:0]  frm_op_q, frm_op_d;
   logic [31:0] a_q, a_d, b_q, b_d, c_q, c_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] res_q, res_d;
   logic [4:0]  rfl_q, rfl_d;
   logic        ill_q, ill_d;
   logic        to_q, to_d;
   logic [2:0]  frm_q, frm_d;
   logic [4:0]  ffl_q, ffl_d;

   logic [2:0]  rm_res;
   logic        sel_ok;
   logic        illegal;
   logic [4:0]  cap_flags;

   always_comb begin
      sel_ok = 1'b1;
      case (bus.req_alusel)
         5'd4, 5'd5, 5'd18, 5'd20, 5'd22, 5'd23, 5'd24, 5'd26, 5'd28, 5'd30: sel_ok = 1'b0;
         default: sel_ok = 1'b1;
      endcase
   end

   // Dynamic rm uses the frm visible before any same-cycle CSR write.
   assign rm_res  = (bus.req_rm == 3'b111) ? frm_q : bus.req_rm;
   assign illegal = !sel_ok || (rm_res >= 3'b101);

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      frm_op_d  = frm_op_q;
      a_d       = a_q;
      b_d       = b_q;
      c_d       = c_q;
      cnt_d     = cnt_q;
      res_d     = res_q;
      rfl_d     = rfl_q;
      ill_d     = ill_q;
      to_d      = to_q;
      cap_flags = 5'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               sel_d    = bus.req_alusel;
               frm_op_d = rm_res;
               a_d      = bus.req_a;
               b_d      = bus.req_b;
               c_d      = bus.req_c;
               cnt_d    = 8'd0;
               res_d    = 32'd0;
               rfl_d    = 5'd0;
               to_d     = 1'b0;
               ill_d    = illegal;
               state_d  = illegal ? RESP : BUSY;
            end
         end
         BUSY: begin
            if (bus.alu_done) begin
               res_d     = bus.alu_result;
               rfl_d     = bus.alu_flags;
               cap_flags = bus.alu_flags;
               state_d   = RESP;
            end else if (cnt_q == CNT_LAST) begin
               res_d     = 32'h7FC0_0000;
               rfl_d     = 5'b10000;
               to_d      = 1'b1;
               cap_flags = 5'b10000;
               state_d   = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP: begin
            if (bus.resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Captured flags OR on top of a same-cycle fflags write.
   always_comb begin
      ffl_d = ((bus.csr_we && bus.csr_addr[0]) ? bus.csr_wdata[4:0] : ffl_q) | cap_flags;
      frm_d = frm_q;
      if (bus.csr_we && bus.csr_addr == 2'b10) frm_d = bus.csr_wdata[2:0];
      if (bus.csr_we && bus.csr_addr == 2'b11) frm_d = bus.csr_wdata[7:5];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         sel_q    <= 5'd0;
         frm_op_q <= 3'd0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         c_q      <= 32'd0;
         cnt_q    <= 8'd0;
         res_q    <= 32'd0;
         rfl_q    <= 5'd0;
         ill_q    <= 1'b0;
         to_q     <= 1'b0;
         frm_q    <= 3'd0;
         ffl_q    <= 5'd0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         frm_op_q <= frm_op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         c_q      <= c_d;
         cnt_q    <= cnt_d;
         res_q    <= res_d;
         rfl_q    <= rfl_d;
         ill_q    <= ill_d;
         to_q     <= to_d;
         frm_q    <= frm_d;
         ffl_q    <= ffl_d;
      end
   end

   always_comb begin
      case (bus.csr_addr)
         2'b01:   bus.csr_rdata = {3'b0, ffl_q};
         2'b10:   bus.csr_rdata = {5'b0, frm_q};
         2'b11:   bus.csr_rdata = {frm_q, ffl_q};
         default: bus.csr_rdata = 8'd0;
      endcase
   end

   assign bus.req_ready    = (state_q == IDLE);
   assign bus.resp_valid   = (state_q == RESP);
   assign bus.alu_start    = (state_q == BUSY);
   assign bus.resp_result  = res_q;
   assign bus.resp_flags   = rfl_q;
   assign bus.resp_illegal = ill_q;
   assign bus.resp_timeout = to_q;
   assign bus.alu_sel      = sel_q;
   assign bus.alu_frm      = frm_op_q;
   assign bus.alu_a        = a_q;
   assign bus.alu_b        = b_q;
   assign bus.alu_c        = c_q;
   assign bus.fcsr         = {frm_q, ffl_q};
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Randomized bench for fpu_issue_ctrl with a latency-programmable ALU stand-in and an op-level reference model.
module tb_fpu_issue_ctrl;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   fpu_issue_ctrl_if bus();

   fpu_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // ALU stand-in: done in the lat_cur-th consecutive start cycle; lat_cur 0 = never.
   int          lat_cur  = 0;
   logic [31:0] res_cur  = 32'd0;
   logic [4:0]  flg_cur  = 5'd0;
   int          busy_cyc = 0;
   always @(posedge clk) busy_cyc <= bus.alu_start ? busy_cyc + 1 : 0;
   assign bus.alu_done   = bus.alu_start && (lat_cur != 0) && (busy_cyc == lat_cur - 1);
   assign bus.alu_result = res_cur;
   assign bus.alu_flags  = flg_cur;

   logic [2:0] m_frm = 3'd0;
   logic [4:0] m_ffl = 5'd0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit sel_legal(input logic [4:0] s);
      return (s <= 5'd3) || (s >= 5'd6 && s <= 5'd17) || s == 5'd19 || s == 5'd21 ||
             s == 5'd25 || s == 5'd27 || s == 5'd29 || s == 5'd31;
   endfunction

   task automatic check_csr();
      logic [7:0] e;
      @(negedge clk);
      for (int a = 0; a < 4; a++) begin
         bus.csr_addr = a[1:0];
         #1;
         case (a)
            1:       e = {3'b0, m_ffl};
            2:       e = {5'b0, m_frm};
            3:       e = {m_frm, m_ffl};
            default: e = 8'd0;
         endcase
         chk("csr_rdata", {24'd0, bus.csr_rdata}, {24'd0, e});
      end
      bus.csr_addr = 2'b00;
      chk("fcsr", {24'd0, bus.fcsr}, {24'd0, m_frm, m_ffl});
   endtask

   task automatic csr_write(input logic [1:0] addr, input logic [7:0] d);
      @(negedge clk);
      bus.csr_addr  = addr;
      bus.csr_wdata = d;
      bus.csr_we    = 1'b1;
      @(negedge clk);
      bus.csr_we    = 1'b0;
      bus.csr_addr  = 2'b00;
      if (addr[0]) m_ffl = d[4:0];
      if (addr == 2'b10) m_frm = d[2:0];
      if (addr == 2'b11) m_frm = d[7:5];
   endtask

   task automatic do_op(input logic [4:0] sel, input logic [2:0] rm, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c, input int lat,
                        input logic [31:0] res, input logic [4:0] flg, input int hold,
                        input bit clr_at_done);
      logic [2:0]  erm;
      bit          ill, tmo, got;
      int          n, starts, en, es;
      logic [31:0] eres;
      logic [4:0]  efl;
      erm = (rm == 3'b111) ? m_frm : rm;
      ill = !sel_legal(sel) || (erm >= 3'd5);
      tmo = !ill && (lat == 0 || lat > TO);
      en  = ill ? 1 : (tmo ? TO + 1 : lat + 1);
      es  = ill ? 0 : (tmo ? TO : lat);
      eres = ill ? 32'd0 : (tmo ? 32'h7FC0_0000 : res);
      efl  = ill ? 5'd0 : (tmo ? 5'b10000 : flg);

      @(negedge clk);
      chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
      lat_cur = lat;
      res_cur = res;
      flg_cur = flg;
      bus.req_alusel = sel;
      bus.req_rm     = rm;
      bus.req_a      = a;
      bus.req_b      = b;
      bus.req_c      = c;
      bus.req_valid  = 1'b1;
      n = 0; starts = 0; got = 0;
      while (n < TO + 20 && !got) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         bus.csr_we    = 1'b0;
         n++;
         if (n == 1) chk("req_ready_after_accept", {31'd0, bus.req_ready}, 32'd0);
         if (bus.alu_start) begin
            if (starts == 0) begin
               chk("alu_frm", {29'd0, bus.alu_frm}, {29'd0, erm});
               chk("alu_sel", {27'd0, bus.alu_sel}, {27'd0, sel});
               chk("alu_a", bus.alu_a, a);
               chk("alu_c", bus.alu_c, c);
            end
            starts++;
            if (clr_at_done && bus.alu_done) begin
               bus.csr_addr  = 2'b01;
               bus.csr_wdata = 8'd0;
               bus.csr_we    = 1'b1;
               m_ffl = 5'd0;
            end
         end
         if (bus.resp_valid) got = 1;
      end
      bus.csr_addr = 2'b00;
      chk("resp_latency", n, en);
      chk("start_cycles", starts, es);
      if (!ill) m_ffl = m_ffl | efl;
      for (int h = 0; h <= hold; h++) begin
         if (h > 0) @(negedge clk);
         chk("resp_valid", {31'd0, bus.resp_valid}, 32'd1);
         chk("resp_result", bus.resp_result, eres);
         chk("resp_flags", {27'd0, bus.resp_flags}, {27'd0, efl});
         chk("resp_illegal", {31'd0, bus.resp_illegal}, {31'd0, ill});
         chk("resp_timeout", {31'd0, bus.resp_timeout}, {31'd0, tmo});
         chk("req_ready_resp", {31'd0, bus.req_ready}, 32'd0);
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      chk("resp_valid_drop", {31'd0, bus.resp_valid}, 32'd0);
      chk("req_ready_back", {31'd0, bus.req_ready}, 32'd1);
      chk("fcsr_after_op", {24'd0, bus.fcsr}, {24'd0, m_frm, m_ffl});
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_alusel = 5'd0;
      bus.req_rm     = 3'd0;
      bus.req_a      = 32'd0;
      bus.req_b      = 32'd0;
      bus.req_c      = 32'd0;
      bus.resp_ready = 1'b0;
      bus.csr_addr   = 2'b00;
      bus.csr_we     = 1'b0;
      bus.csr_wdata  = 8'd0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      chk("rst_alu_start", {31'd0, bus.alu_start}, 32'd0);
      chk("rst_fcsr", {24'd0, bus.fcsr}, 32'd0);
      chk("rst_resp_result", bus.resp_result, 32'd0);
      chk("rst_alu_a", bus.alu_a, 32'd0);
      rst = 1'b1;

      // fadd 1.0 + 2.0, four-cycle ALU
      do_op(5'b00000, 3'b000, 32'h3F80_0000, 32'h4000_0000, 32'd0, 4, 32'h4040_0000, 5'd0, 0, 0);
      // dynamic rm from frm, then dynamic rm resolving to a reserved mode
      csr_write(2'b10, 8'h03);
      do_op(5'b00110, 3'b111, 32'h1234_5678, 32'h8000_0000, 32'd0, 1, 32'h9234_5678, 5'd0, 0, 0);
      csr_write(2'b10, 8'h05);
      do_op(5'b00110, 3'b111, 32'h1, 32'h2, 32'h3, 1, 32'hDEAD_BEEF, 5'd1, 0, 0);
      csr_write(2'b10, 8'h00);
      // sticky accumulation, then a clear colliding with a capture
      do_op(5'b00001, 3'b001, 32'h5, 32'h6, 32'h7, 2, 32'hAAAA_0001, 5'b00001, 0, 0);
      do_op(5'b00011, 3'b010, 32'h8, 32'h9, 32'hA, 3, 32'hAAAA_0002, 5'b00100, 0, 0);
      check_csr();
      do_op(5'b00010, 3'b000, 32'hB, 32'hC, 32'hD, 2, 32'hAAAA_0003, 5'b10000, 0, 1);
      check_csr();
      // watchdog
      do_op(5'b01000, 3'b000, 32'h11, 32'h22, 32'h33, 0, 32'h0, 5'd0, 0, 0);
      // long-held response on an illegal select
      do_op(5'b10100, 3'b000, 32'h44, 32'h55, 32'h66, 1, 32'h0, 5'd0, 5, 0);
      // done on the final watchdog cycle wins
      do_op(5'b10011, 3'b100, 32'h77, 32'h88, 32'h99, TO, 32'h3333_3333, 5'b01000, 0, 0);

      // reset while BUSY
      csr_write(2'b11, 8'h6B);
      @(negedge clk);
      lat_cur = 0;
      bus.req_alusel = 5'b00000;
      bus.req_rm     = 3'b000;
      bus.req_a      = 32'hCAFE_F00D;
      bus.req_valid  = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_rst_alu_start", {31'd0, bus.alu_start}, 32'd1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      m_frm = 3'd0;
      m_ffl = 5'd0;
      chk("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("midrst_alu_start", {31'd0, bus.alu_start}, 32'd0);
      chk("midrst_fcsr", {24'd0, bus.fcsr}, 32'd0);
      chk("midrst_alu_a", bus.alu_a, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midrst_no_resp", {31'd0, bus.resp_valid}, 32'd0);
      end

      for (int i = 0; i < 40; i++) begin
         logic [4:0]  s;
         logic [2:0]  r;
         if ($urandom_range(0, 3) == 0)
            csr_write(2'($urandom_range(1, 3)), 8'($urandom_range(0, 255)));
         if ($urandom_range(0, 2) == 0)
            csr_write(2'b10, 8'($urandom_range(0, 4)));
         s = 5'($urandom_range(0, 31));
         r = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
         do_op(s, r, $urandom, $urandom, $urandom, $urandom_range(0, 11), $urandom,
               5'($urandom_range(0, 31)), $urandom_range(0, 2), ($urandom_range(0, 4) == 0));
         if (i % 8 == 0) check_csr();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
